// File: rtl/path_delay_launch_capture.sv
// Launch/capture controller for single-path delay test: toggles path_in, samples
// path_out SETTLE_CYCLES later and accumulates pass/fail results.
module path_delay_launch_capture #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_tests,
  input  logic             rise_first,
  input  logic             invert,
  output logic             path_in,
  input  logic             path_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic             first_fail_vld,
  output logic             fail_rise,
  output logic             fail_fall
);

  localparam int WAIT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  localparam logic [2:0] IDLE        = 3'd0;
  localparam logic [2:0] INIT        = 3'd1;
  localparam logic [2:0] LAUNCH_WAIT = 3'd2;
  localparam logic [2:0] CAPTURE     = 3'd3;
  localparam logic [2:0] DONE        = 3'd4;

  logic [2:0]        state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0]  remaining;
  logic [CNT_W-1:0]  test_idx;
  logic              inv_lat;
  logic              mismatch;

  assign busy     = (state == INIT) || (state == LAUNCH_WAIT) || (state == CAPTURE);
  assign done     = (state == DONE);
  assign mismatch = path_out != (path_in ^ inv_lat);

  // Sampling happens on the last LAUNCH_WAIT edge; CAPTURE is the following cycle
  // that decides between the next launch and DONE. A zero-test run passes through
  // CAPTURE too, which places its done pulse one edge after the accept edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      remaining      <= '0;
      test_idx       <= '0;
      inv_lat        <= 1'b0;
      path_in        <= 1'b0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      first_fail_idx <= '0;
      first_fail_vld <= 1'b0;
      fail_rise      <= 1'b0;
      fail_fall      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            remaining      <= num_tests;
            inv_lat        <= invert;
            test_idx       <= '0;
            wait_cnt       <= WAIT_LOAD;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail_idx <= '0;
            first_fail_vld <= 1'b0;
            fail_rise      <= 1'b0;
            fail_fall      <= 1'b0;
            if (num_tests == '0) begin
              state <= CAPTURE;
            end else begin
              path_in <= ~rise_first;
              state   <= INIT;
            end
          end
        end
        INIT: begin
          if (wait_cnt == '0) begin
            path_in  <= ~path_in;
            wait_cnt <= WAIT_LOAD;
            state    <= LAUNCH_WAIT;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        LAUNCH_WAIT: begin
          if (wait_cnt == '0) begin
            remaining <= remaining - 1'b1;
            // path_in already holds the launched value, so it also gives the direction
            if (mismatch) begin
              if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + 1'b1;
              if (path_in) fail_rise <= 1'b1;
              else         fail_fall <= 1'b1;
              if (!first_fail_vld) begin
                first_fail_idx <= test_idx;
                first_fail_vld <= 1'b1;
              end
            end else if (pass_cnt != CNT_MAX) begin
              pass_cnt <= pass_cnt + 1'b1;
            end
            state <= CAPTURE;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        CAPTURE: begin
          if (remaining != '0) begin
            path_in  <= ~path_in;
            test_idx <= test_idx + 1'b1;
            wait_cnt <= WAIT_LOAD;
            state    <= LAUNCH_WAIT;
          end else begin
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_path_delay_launch_capture.sv
// Directed bench for path_delay_launch_capture with a delay-line path model
// having separate rise/fall delays and optional inversion.
module tb_path_delay_launch_capture;

  localparam int CNT_W = 16;
  localparam int MAXW  = 100;

  logic             clk, rst, start, rise_first, invert;
  logic [CNT_W-1:0] num_tests;
  logic             path_in, path_out, busy, done;
  logic [CNT_W-1:0] pass_cnt, fail_cnt, first_fail_idx;
  logic             first_fail_vld, fail_rise, fail_fall;

  int tests_run, tests_failed;
  int dly_rise, dly_fall;
  logic inv_model;
  logic hist [0:15];
  logic pin_trace  [0:MAXW-1];
  logic busy_trace [0:MAXW-1];
  logic done_post;

  path_delay_launch_capture #(.SETTLE_CYCLES(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_tests(num_tests),
    .rise_first(rise_first), .invert(invert), .path_in(path_in), .path_out(path_out),
    .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .first_fail_idx(first_fail_idx), .first_fail_vld(first_fail_vld),
    .fail_rise(fail_rise), .fail_fall(fail_fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // hist[j] is path_in as it stood j edges ago; slower edge direction gates the other
  always @(posedge clk) begin
    #1;
    for (int j = 15; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = path_in;
  end

  assign path_out = ((dly_rise >= dly_fall) ? (hist[dly_rise] & hist[dly_fall])
                                            : (hist[dly_rise] | hist[dly_fall])) ^ inv_model;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic launch_run(input logic [CNT_W-1:0] n, input logic rf, input logic inv,
                            input int mid_at, output int done_at);
    @(negedge clk);
    num_tests = n; rise_first = rf; invert = inv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pin_trace[0] = path_in; busy_trace[0] = busy;
    done_at = -1;
    for (int off = 1; off < MAXW && done_at < 0; off++) begin
      @(posedge clk); #1;
      pin_trace[off] = path_in; busy_trace[off] = busy;
      if (done) done_at = off;
      if (off == mid_at) begin
        start = 1'b1; num_tests = 16'd7; invert = ~inv; rise_first = ~rf;
      end else if (off == mid_at + 1) begin
        start = 1'b0; num_tests = n; invert = inv; rise_first = rf;
      end
    end
    @(posedge clk); #1;
    done_post = done;
  endtask

  task automatic test_reset();
    dly_rise = 2; dly_fall = 2; inv_model = 1'b0;
    do_reset();
    tests_run++; if (path_in !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset.path_in got %b want 0", path_in); end
    tests_run++; if ({busy, done} !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset.busy_done got %b want 00", {busy, done}); end
    tests_run++; if ({pass_cnt, fail_cnt, first_fail_idx} !== '0) begin tests_failed++; $display("[TB] FAIL reset.counters got %0d/%0d/%0d want 0/0/0", pass_cnt, fail_cnt, first_fail_idx); end
    tests_run++; if ({first_fail_vld, fail_rise, fail_fall} !== 3'b000) begin tests_failed++; $display("[TB] FAIL reset.flags got %b want 000", {first_fail_vld, fail_rise, fail_fall}); end
  endtask

  task automatic test_pass();
    int d;
    dly_rise = 2; dly_fall = 2; inv_model = 1'b0;
    do_reset();
    launch_run(16'd2, 1'b1, 1'b0, -1, d);
    tests_run++; if (d != 14) begin tests_failed++; $display("[TB] FAIL pass.done_at got %0d want 14", d); end
    tests_run++; if ({pin_trace[0], pin_trace[3], pin_trace[4], pin_trace[8], pin_trace[9]} !== 5'b00110) begin tests_failed++; $display("[TB] FAIL pass.path_in_seq got %b want 00110", {pin_trace[0], pin_trace[3], pin_trace[4], pin_trace[8], pin_trace[9]}); end
    tests_run++; if ({busy_trace[0], busy_trace[13], busy_trace[14]} !== 3'b110) begin tests_failed++; $display("[TB] FAIL pass.busy_seq got %b want 110", {busy_trace[0], busy_trace[13], busy_trace[14]}); end
    tests_run++; if (done_post !== 1'b0) begin tests_failed++; $display("[TB] FAIL pass.done_width got %b want 0", done_post); end
    tests_run++; if (pass_cnt !== 16'd2 || fail_cnt !== 16'd0) begin tests_failed++; $display("[TB] FAIL pass.counts got %0d/%0d want 2/0", pass_cnt, fail_cnt); end
    tests_run++; if (first_fail_vld !== 1'b0) begin tests_failed++; $display("[TB] FAIL pass.first_fail_vld got %b want 0", first_fail_vld); end
  endtask

  task automatic test_too_slow();
    int d;
    dly_rise = 6; dly_fall = 6; inv_model = 1'b0;
    do_reset();
    launch_run(16'd2, 1'b1, 1'b0, -1, d);
    tests_run++; if (pass_cnt !== 16'd0 || fail_cnt !== 16'd2) begin tests_failed++; $display("[TB] FAIL slow.counts got %0d/%0d want 0/2", pass_cnt, fail_cnt); end
    tests_run++; if ({fail_rise, fail_fall} !== 2'b11) begin tests_failed++; $display("[TB] FAIL slow.dir got %b want 11", {fail_rise, fail_fall}); end
    tests_run++; if (first_fail_vld !== 1'b1 || first_fail_idx !== 16'd0) begin tests_failed++; $display("[TB] FAIL slow.first got vld=%b idx=%0d want vld=1 idx=0", first_fail_vld, first_fail_idx); end
  endtask

  task automatic test_slow_rise();
    int d;
    dly_rise = 6; dly_fall = 1; inv_model = 1'b0;
    do_reset();
    launch_run(16'd4, 1'b1, 1'b0, -1, d);
    tests_run++; if (d != 24) begin tests_failed++; $display("[TB] FAIL slow_rise.done_at got %0d want 24", d); end
    tests_run++; if (pass_cnt !== 16'd2 || fail_cnt !== 16'd2) begin tests_failed++; $display("[TB] FAIL slow_rise.counts got %0d/%0d want 2/2", pass_cnt, fail_cnt); end
    tests_run++; if ({fail_rise, fail_fall} !== 2'b10) begin tests_failed++; $display("[TB] FAIL slow_rise.dir got %b want 10", {fail_rise, fail_fall}); end
    tests_run++; if (first_fail_idx !== 16'd0 || first_fail_vld !== 1'b1) begin tests_failed++; $display("[TB] FAIL slow_rise.first got idx=%0d vld=%b want idx=0 vld=1", first_fail_idx, first_fail_vld); end
    do_reset();
    launch_run(16'd4, 1'b0, 1'b0, -1, d);
    tests_run++; if (pass_cnt !== 16'd2 || fail_cnt !== 16'd2) begin tests_failed++; $display("[TB] FAIL slow_rise_f.counts got %0d/%0d want 2/2", pass_cnt, fail_cnt); end
    tests_run++; if ({fail_rise, fail_fall} !== 2'b10) begin tests_failed++; $display("[TB] FAIL slow_rise_f.dir got %b want 10", {fail_rise, fail_fall}); end
    tests_run++; if (first_fail_idx !== 16'd1) begin tests_failed++; $display("[TB] FAIL slow_rise_f.first_idx got %0d want 1", first_fail_idx); end
  endtask

  task automatic test_inverted();
    int d;
    dly_rise = 1; dly_fall = 1; inv_model = 1'b1;
    do_reset();
    launch_run(16'd3, 1'b1, 1'b1, -1, d);
    tests_run++; if (pass_cnt !== 16'd3 || fail_cnt !== 16'd0) begin tests_failed++; $display("[TB] FAIL inv.counts got %0d/%0d want 3/0", pass_cnt, fail_cnt); end
    do_reset();
    launch_run(16'd3, 1'b1, 1'b0, -1, d);
    tests_run++; if (pass_cnt !== 16'd0 || fail_cnt !== 16'd3) begin tests_failed++; $display("[TB] FAIL noinv.counts got %0d/%0d want 0/3", pass_cnt, fail_cnt); end
  endtask

  task automatic test_zero();
    int d;
    dly_rise = 2; dly_fall = 2; inv_model = 1'b0;
    do_reset();
    launch_run(16'd1, 1'b1, 1'b0, -1, d);
    tests_run++; if (path_in !== 1'b1 || pass_cnt !== 16'd1) begin tests_failed++; $display("[TB] FAIL zero.pre got path_in=%b pass=%0d want 1/1", path_in, pass_cnt); end
    launch_run(16'd0, 1'b1, 1'b0, -1, d);
    tests_run++; if (d != 1) begin tests_failed++; $display("[TB] FAIL zero.done_at got %0d want 1", d); end
    tests_run++; if (busy_trace[0] !== 1'b1) begin tests_failed++; $display("[TB] FAIL zero.busy got %b want 1", busy_trace[0]); end
    tests_run++; if (path_in !== 1'b1 || pin_trace[0] !== 1'b1) begin tests_failed++; $display("[TB] FAIL zero.path_in got %b/%b want 1/1", pin_trace[0], path_in); end
    tests_run++; if ({pass_cnt, fail_cnt} !== '0) begin tests_failed++; $display("[TB] FAIL zero.counts got %0d/%0d want 0/0", pass_cnt, fail_cnt); end
  endtask

  task automatic test_ignored_start();
    int d;
    dly_rise = 2; dly_fall = 2; inv_model = 1'b0;
    do_reset();
    launch_run(16'd2, 1'b1, 1'b0, 6, d);
    tests_run++; if (d != 14) begin tests_failed++; $display("[TB] FAIL busy_start.done_at got %0d want 14", d); end
    tests_run++; if ({pin_trace[8], pin_trace[9]} !== 2'b10) begin tests_failed++; $display("[TB] FAIL busy_start.path_in got %b want 10", {pin_trace[8], pin_trace[9]}); end
    tests_run++; if (pass_cnt !== 16'd2 || fail_cnt !== 16'd0) begin tests_failed++; $display("[TB] FAIL busy_start.counts got %0d/%0d want 2/0", pass_cnt, fail_cnt); end
  endtask

  task automatic test_reset_mid_run();
    int d;
    logic done_seen;
    dly_rise = 2; dly_fall = 2; inv_model = 1'b0;
    do_reset();
    @(negedge clk);
    num_tests = 16'd2; rise_first = 1'b1; invert = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    tests_run++; if ({path_in, busy, done} !== 3'b000) begin tests_failed++; $display("[TB] FAIL mid_reset.outputs got %b want 000", {path_in, busy, done}); end
    tests_run++; if ({pass_cnt, fail_cnt, first_fail_vld, fail_rise, fail_fall} !== '0) begin tests_failed++; $display("[TB] FAIL mid_reset.results got %0d/%0d want 0/0", pass_cnt, fail_cnt); end
    done_seen = 1'b0;
    repeat (2) begin @(negedge clk); if (done) done_seen = 1'b1; end
    rst = 1'b0;
    repeat (20) begin @(negedge clk); if (done) done_seen = 1'b1; end
    tests_run++; if (done_seen !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_reset.no_done got %b want 0", done_seen); end
    launch_run(16'd2, 1'b1, 1'b0, -1, d);
    tests_run++; if (d != 14) begin tests_failed++; $display("[TB] FAIL mid_reset.rerun_done got %0d want 14", d); end
    tests_run++; if (pass_cnt !== 16'd2 || fail_cnt !== 16'd0 || pin_trace[4] !== 1'b1) begin tests_failed++; $display("[TB] FAIL mid_reset.rerun got %0d/%0d pin4=%b want 2/0 pin4=1", pass_cnt, fail_cnt, pin_trace[4]); end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    for (int j = 0; j < 16; j++) hist[j] = 1'b0;
    rst = 1'b1; start = 1'b0; num_tests = '0; rise_first = 1'b0; invert = 1'b0;
    dly_rise = 2; dly_fall = 2; inv_model = 1'b0;
    test_reset();
    test_pass();
    test_too_slow();
    test_slow_rise();
    test_inverted();
    test_zero();
    test_ignored_start();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/path_delay_launch_capture.md
# path_delay_launch_capture

Sequential test controller for the extracted single-path netlists used in path-delay ATPG. It drives the path's primary input with a controlled transition sequence and samples the path's primary output a programmable number of cycles after each launch. Each capture is checked against the expected settled value, and the block records pass/fail counts and the direction of any slow transition. It sits directly around a combinational single-path block: upstream as the launch driver, downstream as the capture/compare stage.

## Interface
- SETTLE_CYCLES, 4, cycles from launch edge to capture edge; legal range ≥1.
- CNT_W, 16, width of test count and result counters.

- clk  in  1  sole clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- num_tests  in  CNT_W  number of transitions to launch; sampled with start.
- rise_first  in  1  1 = first launch is 0→1 on path_in; 0 = first launch is 1→0.
- invert  in  1  path parity; expected path_out = path_in ^ invert; sampled with start.
- path_in  out  1  drives the path primary input.
- path_out  in  1  path primary output; combinational from path_in.
- busy  out  1  high from the start-accept edge until the done edge.
- done  out  1  one-cycle pulse at end of run.
- pass_cnt  out  CNT_W  captures that matched the expected value; saturating.
- fail_cnt  out  CNT_W  captures that mismatched; saturating.
- first_fail_idx  out  CNT_W  index (0-based) of the first failing test.
- first_fail_vld  out  1  first_fail_idx is valid.
- fail_rise  out  1  sticky: some failing test had a rising transition on path_in.
- fail_fall  out  1  sticky: some failing test had a falling transition on path_in.

## Operation
- States: IDLE, INIT, LAUNCH_WAIT, CAPTURE, DONE.
- IDLE + start: latch num_tests and invert; clear all result outputs; set busy.
  - num_tests = 0: go to DONE. path_in is unchanged.
  - Otherwise: set path_in = ~rise_first and enter INIT.
- INIT: hold path_in for SETTLE_CYCLES cycles so the path settles to the initial value. No check is made.
- LAUNCH_WAIT: toggle path_in on entry, then wait. Test k launches rising when (rise_first ^ k[0]) = 1, and falling otherwise. Directions alternate.
- CAPTURE: sample path_out and compare it with path_in ^ invert.
  - Match: pass_cnt +1.
  - Mismatch: fail_cnt +1. Set fail_rise or fail_fall according to test k's direction. If first_fail_vld = 0, load first_fail_idx = k and set first_fail_vld.
  - Tests remaining: go to LAUNCH_WAIT. Otherwise go to DONE.
- DONE: done = 1 and busy = 0 for one cycle, then return to IDLE. Results hold until the next accepted start.
- Counters saturate at 2^CNT_W−1 and do not wrap.
- start while busy is ignored, and num_tests, rise_first and invert changes are not seen during a run. rise_first is read only in the start-accept cycle.
- Reset, asynchronous, any state: state → IDLE. path_in, busy, done, pass_cnt, fail_cnt, first_fail_idx, first_fail_vld, fail_rise and fail_fall all → 0. Any run in progress is abandoned with no done pulse.

## Timing
- Edge S: start is accepted and busy rises; path_in takes its initial value.
- Launch of test k: edge L_k = S + SETTLE_CYCLES + k·(SETTLE_CYCLES+1).
- Capture of test k: edge L_k + SETTLE_CYCLES. path_out is sampled there, and counters and flags update on the same edge.
- Next launch: one cycle after the capture, giving a test period of SETTLE_CYCLES+1 cycles.
- done pulse: the edge after the last capture, at S + SETTLE_CYCLES + N·(SETTLE_CYCLES+1). busy falls on the same edge.
- num_tests = 0: done at S+1.
- The path is combinational, so path_out has no synchronizer. A transition that has not propagated by the capture edge counts as a delay failure.

## Test plan
- Bench path model: a D-cycle delay line with optional inversion. Separate rise and fall delays are configurable.
- Pass case. SETTLE=4, N=2, rise_first=1, invert=0, D=2 → path_in goes 0, then 1 at S+4, then 0 at S+9. Captures at S+8 and S+13. done at S+14; pass_cnt=2, fail_cnt=0, first_fail_vld=0.
- Too slow. SETTLE=4, N=2, D=6 → fail_cnt=2, fail_rise=1, fail_fall=1, first_fail_idx=0, first_fail_vld=1.
- Slow-to-rise only. N=4, rise_first=1, rise delay 6, fall delay 1 → pass_cnt=2, fail_cnt=2, fail_rise=1, fail_fall=0, first_fail_idx=0. Repeat with rise_first=0 → first_fail_idx=1.
- Inverted path. invert=1, inverting model with D=1, N=3 → pass_cnt=3. The same model with invert=0 → fail_cnt=3.
- Zero tests and ignored start. num_tests=0 → done at S+1, path_in unchanged, all counters 0. A start pulse asserted mid-run → no effect on the timing or results of the active run.
- Reset mid-run. Assert rst at S+6, between clock edges → all outputs are 0 immediately and no done pulse appears. A fresh start after release behaves exactly as in the pass case.
